// File: rtl/dircc_multi_send_handler.sv
// dircc_multi_send_handler: drains per-pin RTS counters with round-robin arbitration, then writes device state back
module dircc_multi_send_handler #(
  parameter int ADDRESS_MEM_WIDTH = 32,
  parameter int NUM_PINS = 4,
  parameter int RTS_WIDTH = 16,
  parameter int COUNT_WIDTH = 16,
  parameter int PACKET_DATA_WIDTH = 32,
  localparam int PW = NUM_PINS > 1 ? $clog2(NUM_PINS) : 1,
  localparam int RW = NUM_PINS * RTS_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address,
  input  logic                         start,
  input  logic [RW-1:0]                rts_in,
  input  logic [COUNT_WIDTH-1:0]       count_in,
  input  logic                         done_in,
  input  logic                         abort,
  output logic [PACKET_DATA_WIDTH-1:0] packet_out,
  output logic [PW-1:0]                packet_out_pin,
  output logic                         packet_out_valid,
  input  logic                         packet_out_ready,
  output logic [ADDRESS_MEM_WIDTH-1:0] write_address,
  output logic [RW-1:0]                rts_out,
  output logic                         done_out,
  output logic                         stopped_out,
  output logic                         write_state_valid,
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, SEND, WRITEBACK} state_t;
  state_t state;
  logic [RW-1:0] rts_q, rts_dec;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [ADDRESS_MEM_WIDTH-1:0] addr_q;
  logic done_q, aborted_q, found, hs, last;
  logic [PW-1:0] ptr, sel, ptr_nxt;
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (!found && rts_q[((int'(ptr) + i) % NUM_PINS) * RTS_WIDTH +: RTS_WIDTH] != '0) begin
        sel = PW'((int'(ptr) + i) % NUM_PINS);
        found = 1'b1;
      end
    end
  end
  assign hs = state == SEND && packet_out_ready && found;
  assign rts_dec = rts_q - (RW'(1) << (int'(sel) * RTS_WIDTH));
  assign last = hs && rts_dec == '0;
  assign ptr_nxt = sel == PW'(NUM_PINS - 1) ? '0 : sel + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rts_q <= '0;
      count_q <= '0;
      addr_q <= '0;
      done_q <= 1'b0;
      aborted_q <= 1'b0;
      ptr <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        rts_q <= rts_in;
        count_q <= count_in;
        addr_q <= address;
        done_q <= done_in;
        aborted_q <= 1'b0;
        state <= |rts_in ? SEND : WRITEBACK;
      end
    end else if (state == SEND) begin
      if (hs) begin
        rts_q <= rts_dec;
        ptr <= ptr_nxt;
      end
      if (abort || last) begin
        state <= WRITEBACK;
        aborted_q <= abort;
      end
    end else
      state <= IDLE;
  assign packet_out = PACKET_DATA_WIDTH'(count_q);
  assign packet_out_pin = sel;
  assign packet_out_valid = state == SEND;
  assign write_state_valid = state == WRITEBACK;
  assign write_address = addr_q;
  assign rts_out = rts_q;
  assign done_out = done_q;
  assign stopped_out = done_q && rts_q == '0 && !aborted_q;
  assign busy = state != IDLE;
endmodule

// File: doc/dircc_multi_send_handler.md
Name: dircc_multi_send_handler

Overview:
- Parametrised successor of the single-pin counter send handler.
- Drains per-output-pin ready-to-send (RTS) counters for one device, with round-robin pin arbitration and valid/ready backpressure on the packet output.
- Issues one device-state writeback per transaction, including the DONE -> DONE|STOPPED transition.
- Sits between the device state memory and the fabric packet injector inside a DiRCC processing element.

Parameters:
- ADDRESS_MEM_WIDTH, 32, width of device state address.
- NUM_PINS, 4, number of output pins, each with its own RTS counter; must be >= 1.
- RTS_WIDTH, 16, width of each per-pin RTS counter.
- COUNT_WIDTH, 16, width of the device count value carried in packets.
- PACKET_DATA_WIDTH, 32, packet payload width; must be >= COUNT_WIDTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDRESS_MEM_WIDTH  device state address; latched on start, echoed on writeback.
- start  in  1  begin transaction; sampled only in IDLE.
- rts_in  in  NUM_PINS*RTS_WIDTH  packed per-pin RTS counts; pin p is bits [p*RTS_WIDTH +: RTS_WIDTH].
- count_in  in  COUNT_WIDTH  device count value to transmit.
- done_in  in  1  device DONE flag from the read state.
- abort  in  1  terminate transaction early.
- packet_out  out  PACKET_DATA_WIDTH  payload: zero-extended count.
- packet_out_pin  out  max(1,$clog2(NUM_PINS))  source pin index.
- packet_out_valid  out  1  packet present.
- packet_out_ready  in  1  downstream accepts.
- write_address  out  ADDRESS_MEM_WIDTH  latched address.
- rts_out  out  NUM_PINS*RTS_WIDTH  remaining RTS counts at writeback.
- done_out  out  1  DONE flag written back.
- stopped_out  out  1  STOPPED flag written back.
- write_state_valid  out  1  single-cycle writeback strobe.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states IDLE, SEND, WRITEBACK; reset enters IDLE.
- Reset values: packet_out_valid=0, write_state_valid=0, busy=0, all data outputs 0, RR pointer=0, latched RTS=0.
- Reset asserted mid-transaction discards it immediately; no writeback is issued.
- IDLE, start=1:
  - Latch rts_in, count_in, done_in, address in the same cycle.
  - If any latched RTS is nonzero, go to SEND; else go to WRITEBACK.
  - start is ignored outside IDLE.
- SEND:
  - packet_out_valid=1 from the cycle after start (latency 1).
  - Selected pin = first pin with nonzero RTS, searching from the RR pointer upward with wrap modulo NUM_PINS.
  - packet_out = {zeros, latched count}; packet_out_pin = selected pin.
  - While valid && !ready: packet_out and packet_out_pin hold stable; abort is also honoured in this case.
  - On valid && ready: selected pin's RTS decrements by 1; RR pointer becomes (pin+1) mod NUM_PINS.
  - Sustained ready must yield one packet per cycle with no bubbles.
  - If that handshake makes every RTS zero, go to WRITEBACK; packet_out_valid=0 in the next cycle.
  - RTS never underflows; a zero counter is never selected.
- abort=1 in SEND:
  - Go to WRITEBACK next cycle. A handshake in the same cycle still counts and decrements.
  - The abort writeback carries the remaining RTS with done_out=latched done and stopped_out=0.
- WRITEBACK, exactly one cycle:
  - write_state_valid=1; rts_out = latched counters; write_address = latched address.
  - done_out = latched done.
  - stopped_out = latched done AND all RTS zero AND not aborted.
  - Then return to IDLE; busy drops in the following cycle.
- A start in the cycle after WRITEBACK (IDLE) is accepted.
- Arithmetic: RTS decrement is modulo RTS_WIDTH but guarded nonzero. Count is passed through unmodified.

Test Plan:
- NUM_PINS=4, rts_in={0,0,0,3} (pin0=3), count_in=0x0042, done_in=0, ready=1 -> three packets 0x00000042 on pin 0 in consecutive cycles, then one writeback with rts_out=0, done_out=0, stopped_out=0.
- rts pins0..3={1,2,0,1}, ready=1 -> pin order 0,1,3,1,0?no: exact order 0,1,3,1; 4 packets, then writeback.
- rts pin2=2, ready low for 5 cycles after valid -> payload and pin held stable over 5 cycles; then 2 packets; total 7 cycles from first valid to last handshake.
- all rts=0, done_in=1, start -> no packet; write_state_valid one cycle after start with done_out=1, stopped_out=1.
- rts pin1=5, done_in=1, abort after 2 handshakes -> rts_out pin1=3 (or 2 if a handshake coincides with abort), stopped_out=0, done_out=1.
- reset_n low during SEND with rts pin0=4 -> outputs return to reset values asynchronously; no writeback; a new start works normally.
